// File: rtl/csa_resolver.sv
// Purpose : resolves a carry-save (sum, carry) pair into a binary result, CHUNK bits per cycle.
// Latency : WIDTH/CHUNK+1 edges from the accept edge to out_valid (5 with the defaults).
// Backpr. : one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n (sync, active low), flush (sync abort of any in-flight/held op)
//   in_valid/in_ready   : operand pair handshake (in_sum, in_carry with bit 0 = 0, in_tag)
//   out_valid/out_ready : result handshake (out_result, out_cout, out_tag; zero outside DONE)
module csa_resolver #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_accept;
  logic             w_step;

  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic [WIDTH-1:0] r_result;
  logic [TAG_W-1:0] r_tag;
  logic [IDX_W-1:0] r_idx;
  logic             r_cc;
  logic             r_cout;
  logic [CHUNK:0]   w_chunk;

  // The operand registers are shifted right by CHUNK every ADD cycle, so the
  // chunk being resolved always sits in the low CHUNK bits.
  assign w_chunk = {1'b0, r_sum[CHUNK-1:0]}
                 + {1'b0, r_carry[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, r_cc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_step     = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_result = '0;
    out_cout   = 1'b0;
    out_tag    = '0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_ADD;
        end
      end
      S_ADD: begin
        w_step = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid  = 1'b1;
        out_result = r_result;
        out_cout   = r_cout;
        out_tag    = r_tag;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    // Flush wins over accept and over out_ready; the datapath is frozen so
    // nothing of the aborted operation can surface later.
    if (flush) begin
      w_next   = S_IDLE;
      w_accept = 1'b0;
      w_step   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_carry  <= '0;
      r_result <= '0;
      r_tag    <= '0;
      r_idx    <= '0;
      r_cc     <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_sum    <= in_sum;
      r_carry  <= in_carry;
      r_tag    <= in_tag;
      r_result <= '0;
      r_idx    <= '0;
      r_cc     <= 1'b0;
      r_cout   <= 1'b0;
    end else if (w_step) begin
      r_sum    <= r_sum >> CHUNK;
      r_carry  <= r_carry >> CHUNK;
      // Each resolved chunk enters at the top; after NCHUNK steps chunk 0 has
      // reached bit 0 and the result is aligned.
      r_result <= (r_result >> CHUNK) | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
      r_cc     <= w_chunk[CHUNK];
      r_idx    <= r_idx + IDX_W'(1);
      if (r_idx == LAST_IDX) begin
        r_cout <= w_chunk[CHUNK];
      end
    end
  end

endmodule
